// File: rtl/hms_time_core.sv
// hms_time_core: hour:minute:second timekeeping core running entirely on clk.
// A prescaler produces a one-cycle count tick every CLK_HZ/TICK_HZ cycles while
// running; set mode freezes counting and allows per-field +1/-1 adjustment with
// modular wrap; a saturating alarm register raises o_alarm on a tick match and
// holds it for ALARM_HOLD ticks unless disarmed or cleared.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_run             advance time on ticks
//   i_set_en          set mode (ticks suppressed, inc/dec active)
//   i_set_sel[1:0]    field select: 0 sec, 1 min, 2 hour, 3 none
//   i_inc, i_dec      one-cycle adjust pulses
//   i_alarm_wr        load alarm registers from i_alarm_hms
//   i_alarm_hms[16:0] {hour[16:12], min[11:6], sec[5:0]}
//   i_alarm_en        alarm arm
//   i_alarm_clr       silence active alarm
//   o_sec, o_min, o_hour   current time
//   o_tick            one-cycle pulse per count tick
//   o_day_wrap        one-cycle pulse on HOUR_MAX:59:59 -> 00:00:00
//   o_alarm           alarm active level
module hms_time_core #(
    parameter int CLK_HZ     = 50000000,
    parameter int TICK_HZ    = 1,
    parameter int HOUR_MAX   = 23,
    parameter int ALARM_HOLD = 60
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_run,
    input  logic        i_set_en,
    input  logic [1:0]  i_set_sel,
    input  logic        i_inc,
    input  logic        i_dec,
    input  logic        i_alarm_wr,
    input  logic [16:0] i_alarm_hms,
    input  logic        i_alarm_en,
    input  logic        i_alarm_clr,
    output logic [5:0]  o_sec,
    output logic [5:0]  o_min,
    output logic [4:0]  o_hour,
    output logic        o_tick,
    output logic        o_day_wrap,
    output logic        o_alarm
);

    localparam int              DIV        = CLK_HZ / TICK_HZ;
    localparam int              PW         = $clog2(DIV);
    localparam logic [PW-1:0]   PRESC_LAST = PW'(DIV - 1);
    localparam logic [4:0]      HMAX       = 5'(HOUR_MAX);
    localparam logic [7:0]      HOLD       = 8'(ALARM_HOLD);

    logic [PW-1:0] presc;
    logic [5:0]    alarm_sec, alarm_min;
    logic [4:0]    alarm_hour;
    logic [7:0]    hold;

    logic          advance, tick_now, adj_up, adj_dn, match;
    logic [5:0]    sec_nxt, min_nxt;
    logic [4:0]    hour_nxt;
    logic          wrap_nxt;
    logic [5:0]    wr_sec, wr_min;
    logic [4:0]    wr_hour;

    assign advance  = i_run & ~i_set_en;
    assign tick_now = advance & (presc == PRESC_LAST);
    // Simultaneous inc and dec cancel out.
    assign adj_up   = i_set_en & i_inc & ~i_dec;
    assign adj_dn   = i_set_en & i_dec & ~i_inc;

    always_comb begin
        sec_nxt  = o_sec;
        min_nxt  = o_min;
        hour_nxt = o_hour;
        wrap_nxt = 1'b0;
        if (tick_now) begin
            if (o_sec == 6'd59) begin
                sec_nxt = 6'd0;
                if (o_min == 6'd59) begin
                    min_nxt = 6'd0;
                    if (o_hour == HMAX) begin
                        hour_nxt = 5'd0;
                        wrap_nxt = 1'b1;
                    end else begin
                        hour_nxt = o_hour + 5'd1;
                    end
                end else begin
                    min_nxt = o_min + 6'd1;
                end
            end else begin
                sec_nxt = o_sec + 6'd1;
            end
        end else if (adj_up || adj_dn) begin
            case (i_set_sel)
                2'd0: sec_nxt = adj_up ? ((o_sec == 6'd59) ? 6'd0 : o_sec + 6'd1)
                                       : ((o_sec == 6'd0) ? 6'd59 : o_sec - 6'd1);
                2'd1: min_nxt = adj_up ? ((o_min == 6'd59) ? 6'd0 : o_min + 6'd1)
                                       : ((o_min == 6'd0) ? 6'd59 : o_min - 6'd1);
                2'd2: hour_nxt = adj_up ? ((o_hour == HMAX) ? 5'd0 : o_hour + 5'd1)
                                        : ((o_hour == 5'd0) ? HMAX : o_hour - 5'd1);
                default: ;
            endcase
        end
    end

    // Out-of-range alarm fields saturate to the field maximum.
    assign wr_sec  = (i_alarm_hms[5:0]   > 6'd59) ? 6'd59 : i_alarm_hms[5:0];
    assign wr_min  = (i_alarm_hms[11:6]  > 6'd59) ? 6'd59 : i_alarm_hms[11:6];
    assign wr_hour = (i_alarm_hms[16:12] > HMAX)  ? HMAX  : i_alarm_hms[16:12];

    // Match uses the post-update time and only fires on tick cycles.
    assign match = tick_now & i_alarm_en &
                   ({hour_nxt, min_nxt, sec_nxt} == {alarm_hour, alarm_min, alarm_sec});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc      <= '0;
            o_sec      <= 6'd0;
            o_min      <= 6'd0;
            o_hour     <= 5'd0;
            o_tick     <= 1'b0;
            o_day_wrap <= 1'b0;
            o_alarm    <= 1'b0;
            hold       <= 8'd0;
            alarm_sec  <= 6'd0;
            alarm_min  <= 6'd0;
            alarm_hour <= 5'd0;
        end else begin
            // Held at zero whenever not advancing, so leaving set mode restarts it.
            presc      <= (tick_now || !advance) ? '0 : presc + PW'(1);
            o_tick     <= tick_now;
            o_day_wrap <= wrap_nxt;
            o_sec      <= sec_nxt;
            o_min      <= min_nxt;
            o_hour     <= hour_nxt;

            if (i_alarm_wr) begin
                alarm_sec  <= wr_sec;
                alarm_min  <= wr_min;
                alarm_hour <= wr_hour;
            end

            if (!i_alarm_en || i_alarm_clr) begin
                o_alarm <= 1'b0;
                hold    <= 8'd0;
            end else if (match) begin
                o_alarm <= 1'b1;
                hold    <= HOLD;
            end else if (tick_now && hold != 8'd0) begin
                hold <= hold - 8'd1;
                if (hold == 8'd1) o_alarm <= 1'b0;
            end
        end
    end

endmodule

// File: doc/hms_time_core.md
Name: hms_time_core

Overview:
- Parametrised single-clock-domain hour:minute:second timekeeping core with an integrated prescaler, field set/adjust, and a programmable alarm with hold and clear.
- Successor to the current min:sec counter chain. Adds an hour field, configurable hour modulus, and decrement on set.
- Derived clocks are replaced by one-cycle enables, so all state runs on clk.
- Sits between the switch debouncers/mode controller (upstream) and the digit-split, segment-decoder and buzzer blocks (downstream).

Parameters:
- CLK_HZ, 50000000, frequency of clk in Hz.
- TICK_HZ, 1, count-tick rate. CLK_HZ/TICK_HZ must be an integer of at least 2.
- HOUR_MAX, 23, largest hour value: 23 for a 24 h clock, 11 for a 12 h clock. Range 1..31.
- ALARM_HOLD, 60, number of ticks o_alarm stays asserted after a match. Range 1..255.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_run  in  1  1 = timekeeping advances on ticks
- i_set_en  in  1  1 = set mode: ticks suppressed, inc/dec enabled
- i_set_sel  in  2  field to adjust: 0 = sec, 1 = min, 2 = hour, 3 = none
- i_inc  in  1  one-cycle pulse: +1 on the selected field
- i_dec  in  1  one-cycle pulse: -1 on the selected field
- i_alarm_wr  in  1  one-cycle pulse: load the alarm registers from i_alarm_hms
- i_alarm_hms  in  17  {hour[16:12], min[11:6], sec[5:0]} alarm time
- i_alarm_en  in  1  alarm arm
- i_alarm_clr  in  1  one-cycle pulse: silence the active alarm
- o_sec  out  6  seconds 0..59
- o_min  out  6  minutes 0..59
- o_hour  out  5  hours 0..HOUR_MAX
- o_tick  out  1  one-cycle pulse on each count tick
- o_day_wrap  out  1  one-cycle pulse when the time wraps HOUR_MAX:59:59 -> 00:00:00
- o_alarm  out  1  alarm active (level)

Behaviour:
- Reset: the asynchronous reset clears the following to 0:
  - all outputs;
  - the prescaler;
  - the alarm registers (00:00:00);
  - the hold counter.
- Prescaler, 0..CLK_HZ/TICK_HZ-1:
  - Increments when i_run=1 and i_set_en=0. Otherwise it is held at 0.
  - On the terminal count it returns to 0 and o_tick=1 for the next cycle.
  - First tick occurs CLK_HZ/TICK_HZ cycles after run begins.
- Counting: time registers update in the same clk edge that asserts o_tick.
  - sec 59 -> 0 with carry to min.
  - min 59 -> 0 with carry to hour.
  - hour HOUR_MAX -> 0, which pulses o_day_wrap together with o_tick.
- Set mode (i_set_en=1):
  - i_inc or i_dec alone changes the selected field by 1 on the next edge.
  - Modular wrap within the field: sec/min 59<->0, hour HOUR_MAX<->0.
  - No carry into other fields.
  - i_inc and i_dec in the same cycle: no change.
  - i_set_sel=3: no change.
  - Outside set mode, inc/dec are ignored.
  - Leaving set mode restarts the prescaler from 0.
- Alarm write:
  - i_alarm_wr latches i_alarm_hms on the next edge.
  - Fields above range saturate: sec/min to 59, hour to HOUR_MAX.
  - Writing is allowed in any mode.
- Alarm match is evaluated only on tick cycles, against the post-update time.
  - If i_alarm_en=1 and the time equals the alarm, then o_alarm goes to 1 and the hold counter loads ALARM_HOLD.
  - Each subsequent tick decrements the hold counter. o_alarm drops on the tick at which the counter reaches 0.
  - A new match while the alarm is active reloads the hold counter.
  - Set-mode adjustments never trigger a match.
- Alarm clear priority, highest first: reset, then i_alarm_en=0 (clears o_alarm and the hold counter on the next edge), then i_alarm_clr, then match, then hold decrement.
  - A match in the same cycle as i_alarm_clr leaves o_alarm=0.
- Latency: all outputs are registered. o_sec/o_min/o_hour reflect an inc/dec one cycle after the pulse.
- Reset mid-operation: all state returns to its reset values immediately. Asynchronous assertion is required; deassertion is synchronous to clk.

Test Plan:
- CLK_HZ=4, TICK_HZ=1, HOUR_MAX=23; preset 23:59:58 via set mode, then i_run=1.
  - Required: the tick on cycle 4 gives 23:59:59.
  - The tick on cycle 8 gives 00:00:00 with o_day_wrap=1 for exactly that one cycle.
- HOUR_MAX=11, set mode, sel=2, hour=0:
  - i_dec -> 11.
  - i_inc -> 0.
  - inc+dec together -> 0 unchanged.
  - sel=0, sec=0, i_dec -> 59; min unchanged.
- Alarm write with i_alarm_hms={31,63,63} at HOUR_MAX=23:
  - Required: alarm registers read back as 23:59:59.
  - Run from 23:59:58: o_alarm=1 on the next tick.
- ALARM_HOLD=3, alarm 00:00:05, armed, running from 00:00:04:
  - o_alarm rises on the tick to :05 and falls on the tick to :08.
  - Repeat with i_alarm_clr at :06: o_alarm=0 on the next edge.
- Alarm active, then i_alarm_en=0:
  - o_alarm=0 next cycle.
  - Re-arm at a non-matching time: o_alarm stays 0.
- Running at 00:10:30 with the prescaler mid-count, pulse rst_n low for 1 cycle:
  - Outputs go to 0 immediately.
  - After release the first o_tick arrives exactly CLK_HZ/TICK_HZ cycles later, with i_run=1.
